multiport_register_file: RTL
============================

Name: multiport_register_file

Overview:
Parametrised successor to the core register file. Provides NUM_READ asynchronous read ports and one synchronous write port, and width and depth are configurable. Adds three things the current file lacks: a post-reset clear sweep FSM, per-entry scoreboard pending bits for pipeline hazard detection, and an optional write-to-read bypass. It sits in the decode stage of the pipeline and replaces the fixed 32x32, 2-read register file.

Parameters:
DATA_WIDTH, 32, bits per register
DEPTH, 32, number of registers; must be a power of 2 and at least 2
NUM_READ, 2, number of read ports (1..4)
ZERO_REG, 1, when 1, entry 0 reads as 0, ignores writes and is never pending

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
read_address  in  NUM_READ x ADDR_WIDTH  read addresses; ADDR_WIDTH = $clog2(DEPTH)
read_data  out  NUM_READ x DATA_WIDTH  combinational read data
read_pending  out  NUM_READ  scoreboard bit of each addressed entry
write_address  in  ADDR_WIDTH  write address
write_data  in  DATA_WIDTH  write data
write_enable  in  1  write strobe; also releases the pending bit
reserve_valid  in  1  mark reserve_address as pending
reserve_address  in  ADDR_WIDTH  entry to reserve
init_done  out  1  high once the clear sweep has completed

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- FSM states are CLEAR and READY.
  - rst high at a clk edge: state <= CLEAR, sweep index <= 0, all pending bits <= 0, init_done <= 0.
  - CLEAR: one entry per cycle, entry[index] <= 0 and index++.
  - CLEAR to READY: after the edge that clears entry DEPTH-1. The full sweep takes exactly DEPTH cycles after rst deasserts.
  - READY: stays in READY until the next rst.
- Behaviour during CLEAR:
  - write_enable and reserve_valid are ignored.
  - read_data = 0 and read_pending = 0 on every port.
- Reset mid-sweep or mid-operation restarts the sweep at index 0.
- Reset values: init_done = 0; read_data = 0 and read_pending = 0 until READY.
- Reads: combinational, with no read-port conflicts.
  - read_data[i] = entry[read_address[i]].
  - If ZERO_REG=1 and the address is 0, read_data[i] = 0 and read_pending[i] = 0.
- Writes: on a clk edge in READY with write_enable=1, entry[write_address] <= write_data. The new value is visible on reads after that edge.
  - If ZERO_REG=1, a write to address 0 is dropped.
- Scoreboard, clocked, READY only:
  - reserve_valid sets pending[reserve_address].
  - write_enable clears pending[write_address].
  - Reserve and write to the same address in the same cycle: the reserve wins and the bit ends set, because a new producer has issued.
  - Reserve and write to different addresses in the same cycle: both take effect.
  - Reserving an entry that is already pending leaves it set.
- Address width rule: addresses are exactly ADDR_WIDTH bits, so there is no out-of-range case.

Optional Feature:
Macro: REGFILE_WRITE_BYPASS_EN
- Defined: when READY, write_enable=1 and read_address[i]==write_address (excluding a dropped zero-register write), read_data[i] = write_data in the same cycle, and read_pending[i] = 0 in the same cycle unless reserve_valid targets that same address.
- Not defined: reads return only the stored value. A write becomes visible one edge later, and the pending bit drops one edge later.

Decomposition:
- Package regfile_pkg:
  - state enum regfile_state_e {CLEAR, READY}
  - helper function addr_width(depth)
  - default parameter constants
- Sub-module regfile_scoreboard: the DEPTH-bit pending vector with reserve/release logic and per-port lookup.
  - Instantiated once.
  - The storage array and FSM stay in the top module.

Test Plan:
- Clear sweep: assert rst for 1 cycle with DEPTH=32 -> init_done=0 for exactly 32 cycles, then 1. All 32 entries read 0. A write of 0xDEADBEEF to entry 5 issued during CLEAR is ignored (entry 5 still reads 0).
- Basic write/read, 4 read ports: write entry 1=0xDEADBEEF and entry 2=0xCAFEBABE. Ports read addresses 1,2,1,0 -> 0xDEADBEEF, 0xCAFEBABE, 0xDEADBEEF, 0x00000000. A write of 0xFFFFFFFF to entry 0 -> still reads 0. A write with write_enable=0 -> no change.
- Scoreboard: reserve entry 3 -> read_pending=1 next cycle. Write 3=0x12345678 -> pending=0 after the edge. Reserve 3 and write 3 in the same cycle -> pending ends 1 and data=the new value.
- Zero register: reserve address 0 -> read_pending=0. With ZERO_REG=0, entry 0 stores 0xA5A5A5A5 and can become pending.
- Bypass: with REGFILE_WRITE_BYPASS_EN defined, write 7=0x0BADF00D while reading 7 -> same-cycle read_data=0x0BADF00D. Without the macro -> old value that cycle, new value next cycle.
- Reset mid-sweep: rst at sweep index 10, then release -> init_done rises exactly DEPTH cycles later. Previously written and pending entries read 0 and not pending.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
// Holds the sweep FSM state encoding, default sizes and the address-width helper.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } regfile_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 32;
  localparam int DEFAULT_NUM_READ   = 2;
  localparam int DEFAULT_ZERO_REG   = 1;

  // A depth of 2 still needs one address bit.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-entry pending bits for hazard detection: reserve sets, write releases,
// reserve wins on a same-address collision. Lookups read 0 until the file is ready.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int NUM_READ   = DEFAULT_NUM_READ,
  parameter int ZERO_REG   = DEFAULT_ZERO_REG,
  parameter int ADDR_WIDTH = addr_width(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ready,
  input  logic                               reserve_valid,
  input  logic [ADDR_WIDTH-1:0]              reserve_address,
  input  logic                               release_valid,
  input  logic [ADDR_WIDTH-1:0]              release_address,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0] read_address,
  output logic [NUM_READ-1:0]                read_pending
);

  logic [DEPTH-1:0] pending_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
        assign pending_reg[gi] = 1'b0;
      end else begin : g_bit
        logic hit_reserve;
        logic hit_release;
        assign hit_reserve = reserve_valid && (reserve_address == ADDR_WIDTH'(gi));
        assign hit_release = release_valid && (release_address == ADDR_WIDTH'(gi));

        always_ff @(posedge clk) begin
          if (rst) begin
            pending_reg[gi] <= 1'b0;
          end else if (ready) begin
            // A new producer issuing outranks the old one completing.
            if (hit_reserve) begin
              pending_reg[gi] <= 1'b1;
            end else if (hit_release) begin
              pending_reg[gi] <= 1'b0;
            end
          end
        end
      end
    end

    for (gi = 0; gi < NUM_READ; gi++) begin : g_lookup
      assign read_pending[gi] = ready & pending_reg[read_address[gi]];
    end
  endgenerate

endmodule

// File: rtl/multiport_register_file.sv
// Parametrised register file: NUM_READ combinational reads, one clocked write,
// post-reset clear sweep and pending scoreboard. Define REGFILE_WRITE_BYPASS_EN
// to forward a same-cycle write onto matching read ports.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int NUM_READ   = DEFAULT_NUM_READ,
  parameter int ZERO_REG   = DEFAULT_ZERO_REG,
  localparam int ADDR_WIDTH = addr_width(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0] read_address,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ-1:0]                read_pending,
  input  logic [ADDR_WIDTH-1:0]              write_address,
  input  logic [DATA_WIDTH-1:0]              write_data,
  input  logic                               write_enable,
  input  logic                               reserve_valid,
  input  logic [ADDR_WIDTH-1:0]              reserve_address,
  output logic                               init_done
);

  regfile_state_e        state_reg, state_next;
  logic [ADDR_WIDTH-1:0] index_reg, index_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic ready;
  logic write_ok;
  logic [NUM_READ-1:0] sb_pending;

  assign ready     = (state_reg == READY);
  assign init_done = ready;
  assign write_ok  = ready && write_enable &&
                     !(ZERO_REG != 0 && write_address == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLEAR;
      index_reg <= '0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    if (state_reg == CLEAR) begin
      index_next = index_reg + ADDR_WIDTH'(1);
      if (index_reg == ADDR_WIDTH'(DEPTH - 1)) begin
        state_next = READY;
      end
    end
  end

  // The sweep and the write port share one memory write port.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = write_address;
    mem_wdata = write_data;
    if (!rst) begin
      if (state_reg == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = index_reg;
        mem_wdata = '0;
      end else if (write_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  regfile_scoreboard #(
    .DEPTH      (DEPTH),
    .NUM_READ   (NUM_READ),
    .ZERO_REG   (ZERO_REG),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .ready           (ready),
    .reserve_valid   (reserve_valid),
    .reserve_address (reserve_address),
    .release_valid   (write_enable),
    .release_address (write_address),
    .read_address    (read_address),
    .read_pending    (sb_pending)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [DATA_WIDTH-1:0] port_data;
      logic                  zero_hit;
      assign zero_hit = (ZERO_REG != 0) && (read_address[gi] == '0);

`ifdef REGFILE_WRITE_BYPASS_EN
      logic fwd_hit;
      logic fwd_release;
      assign fwd_hit     = write_ok && (read_address[gi] == write_address);
      assign fwd_release = fwd_hit &&
                           !(reserve_valid && reserve_address == write_address);

      always_comb begin
        port_data = '0;
        if (ready && !zero_hit) begin
          port_data = fwd_hit ? write_data : mem[read_address[gi]];
        end
      end
      assign read_pending[gi] = sb_pending[gi] & ~fwd_release;
`else
      always_comb begin
        port_data = '0;
        if (ready && !zero_hit) begin
          port_data = mem[read_address[gi]];
        end
      end
      assign read_pending[gi] = sb_pending[gi];
`endif

      assign read_data[gi] = port_data;
    end
  endgenerate

endmodule
